// File: rtl/lock_ramp_pkg.sv
// Shared definitions for the lock-block scan ramp.
// Holds the ramp mode encodings and the Q-format shift used by the lane gains.
package lock_ramp_pkg;

    typedef enum logic [1:0] {
        RAMP_TRI    = 2'd0,
        RAMP_SAW_UP = 2'd1,
        RAMP_SAW_DN = 2'd2,
        RAMP_HOLD   = 2'd3
    } ramp_mode_t;

    localparam int RAMP_R_DEF  = 14;
    localparam int RAMP_QSHIFT = RAMP_R_DEF - 2;

    // Gains are Q2.(R-2): two integer bits, R-2 fraction bits.
    function automatic int q_shift(input int r);
        return r - 2;
    endfunction

endpackage

// File: rtl/gen_ramp_scale.sv
// One scaled ramp lane: y = sat_R((a * factor) >>> (R-2)), two register stages.
// Ports: clk; a (ramp value, signed R); factor (gain, Q2.(R-2)); y (scaled, signed R).
module gen_ramp_scale
    import lock_ramp_pkg::*;
#(
    parameter int R = 14
) (
    input  logic                clk,
    input  logic signed [R-1:0] a,
    input  logic signed [R-1:0] factor,
    output logic signed [R-1:0] y
);

    localparam int SH = q_shift(R);
    localparam int PW = 2 * R;

    logic signed [PW-1:0] prod_q;
    logic signed [PW-1:0] shr;
    logic signed [R-1:0]  sat;

    // The shifted product fits in R bits only when all bits above
    // the R-bit result agree with its sign.
    always_comb begin
        shr = prod_q >>> SH;
        if (shr[PW-1:R-1] == {(PW-R+1){shr[PW-1]}}) begin
            sat = shr[R-1:0];
        end else if (shr[PW-1]) begin
            sat = {1'b1, {(R-1){1'b0}}};
        end else begin
            sat = {1'b0, {(R-1){1'b1}}};
        end
    end

    // Pure datapath: contents flush within two cycles of a held reset.
    always_ff @(posedge clk) begin
        prod_q <= PW'(a) * PW'(factor);
        y      <= sat;
    end

endmodule

// File: rtl/gen_ramp_multi.sv
// Scan ramp (triangle / saw / hold) with dwell, limit triggers and NB scaled lanes.
// Ports: clk, rst (sync, active-high); ramp_* controls; trigger_low/hig pulses;
//   outA ramp value; outB NB scaled lanes (2-cycle lag).
// Option: define RAMP_BURST_EN to add ramp_n_periods / ramp_busy / ramp_periods.
module gen_ramp_multi
    import lock_ramp_pkg::*;
#(
    parameter int R  = 14,
    parameter int CW = 32,
    parameter int NB = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CW-1:0]       ramp_step,
    input  logic [R-2:0]        ramp_inc,
    input  logic signed [R-1:0] ramp_low_lim,
    input  logic signed [R-1:0] ramp_hig_lim,
    input  logic [1:0]          ramp_mode,
    input  logic                ramp_direction,
    input  logic                ramp_enable,
    input  logic                ramp_reset,
    input  logic [NB*R-1:0]     ramp_B_factor,
`ifdef RAMP_BURST_EN
    input  logic [15:0]         ramp_n_periods,
    output logic                ramp_busy,
    output logic [15:0]         ramp_periods,
`endif
    output logic                trigger_low,
    output logic                trigger_hig,
    output logic signed [R-1:0] outA,
    output logic [NB*R-1:0]     outB
);

    localparam int SW = R + 1;

    ramp_mode_t          mode;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       step_q;
    logic                slope_dn;
    logic                step_chg;
    logic                run_en;
    logic                go;
    logic                busy;
    logic                degen;
    logic [R-2:0]        inc_eff;
    logic signed [SW-1:0] a_x, lo_x, hi_x, inc_x, up_x, dn_x;
    logic signed [R-1:0] a_nxt;
    logic signed [R-1:0] rst_val;
    logic                slope_nxt;
    logic                tl_raw, th_raw;
    logic                tl_out, th_out;

    assign mode     = ramp_mode_t'(ramp_mode);
    assign step_chg = (ramp_step != step_q);
    assign run_en   = ramp_enable & busy;
    assign go       = run_en & ~step_chg & (cnt == ramp_step);
    assign degen    = (ramp_low_lim >= ramp_hig_lim);
    assign inc_eff  = (ramp_inc == '0) ? (R-1)'(1) : ramp_inc;

    // One extra bit of headroom so limit tests never see a wrapped sum.
    assign a_x   = SW'(outA);
    assign lo_x  = SW'(ramp_low_lim);
    assign hi_x  = SW'(ramp_hig_lim);
    assign inc_x = signed'({2'b00, inc_eff});
    assign up_x  = a_x + inc_x;
    assign dn_x  = a_x - inc_x;

    // clamp(0, low, hig); a degenerate window pins to low.
    always_comb begin
        rst_val = '0;
        if (degen) begin
            rst_val = ramp_low_lim;
        end else if (!ramp_low_lim[R-1] && ramp_low_lim != '0) begin
            rst_val = ramp_low_lim;
        end else if (ramp_hig_lim[R-1]) begin
            rst_val = ramp_hig_lim;
        end
    end

    always_comb begin
        a_nxt     = outA;
        slope_nxt = slope_dn;
        tl_raw    = 1'b0;
        th_raw    = 1'b0;
        if (go && mode != RAMP_HOLD) begin
            if (degen) begin
                a_nxt = ramp_low_lim;
            end else if (a_x > hi_x) begin
                // Window moved below us: snap in and head back inward.
                a_nxt     = ramp_hig_lim;
                slope_nxt = 1'b1;
            end else if (a_x < lo_x) begin
                a_nxt     = ramp_low_lim;
                slope_nxt = 1'b0;
            end else begin
                unique case (mode)
                    RAMP_TRI: begin
                        if (!slope_dn) begin
                            if (up_x >= hi_x) begin
                                a_nxt     = ramp_hig_lim;
                                slope_nxt = 1'b1;
                                th_raw    = 1'b1;
                            end else begin
                                a_nxt = up_x[R-1:0];
                            end
                        end else begin
                            if (dn_x <= lo_x) begin
                                a_nxt     = ramp_low_lim;
                                slope_nxt = 1'b0;
                                tl_raw    = 1'b1;
                            end else begin
                                a_nxt = dn_x[R-1:0];
                            end
                        end
                    end
                    RAMP_SAW_UP: begin
                        if (a_x >= hi_x) begin
                            a_nxt  = ramp_low_lim;
                            tl_raw = 1'b1;
                        end else if (up_x >= hi_x) begin
                            a_nxt  = ramp_hig_lim;
                            th_raw = 1'b1;
                        end else begin
                            a_nxt = up_x[R-1:0];
                        end
                    end
                    RAMP_SAW_DN: begin
                        if (a_x <= lo_x) begin
                            a_nxt  = ramp_hig_lim;
                            th_raw = 1'b1;
                        end else if (dn_x <= lo_x) begin
                            a_nxt  = ramp_low_lim;
                            tl_raw = 1'b1;
                        end else begin
                            a_nxt = dn_x[R-1:0];
                        end
                    end
                    RAMP_HOLD: begin
                    end
                endcase
            end
        end
    end

    // A trigger right after another one is dropped so pulses stay separated.
    assign tl_out = tl_raw & ~ramp_reset & ~(trigger_low | trigger_hig);
    assign th_out = th_raw & ~ramp_reset & ~(trigger_low | trigger_hig);

    always_ff @(posedge clk) begin
        if (rst) begin
            outA        <= '0;
            slope_dn    <= 1'b0;
            cnt         <= '0;
            step_q      <= ramp_step;
            trigger_low <= 1'b0;
            trigger_hig <= 1'b0;
        end else begin
            step_q      <= ramp_step;
            trigger_low <= tl_out;
            trigger_hig <= th_out;
            if (ramp_reset) begin
                outA <= rst_val;
                cnt  <= '0;
                if (mode == RAMP_TRI) begin
                    slope_dn <= ramp_direction;
                end
            end else begin
                outA     <= a_nxt;
                slope_dn <= slope_nxt;
                if (step_chg || go) begin
                    cnt <= '0;
                end else if (run_en) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef RAMP_BURST_EN
    logic        en_q;
    logic        rr_q;
    logic        busy_q;
    logic [15:0] per_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            rr_q   <= 1'b0;
            busy_q <= 1'b1;
            per_q  <= '0;
        end else begin
            en_q <= ramp_enable;
            rr_q <= ramp_reset;
            if ((ramp_enable && !en_q) || (ramp_reset && !rr_q)) begin
                busy_q <= 1'b1;
                per_q  <= '0;
            end else if (tl_out) begin
                per_q <= per_q + 16'd1;
                // Stopping on a trigger_low leaves outA parked at low_lim.
                if (ramp_n_periods != '0 &&
                    per_q + 16'd1 >= ramp_n_periods) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign busy         = busy_q;
    assign ramp_busy    = busy_q;
    assign ramp_periods = per_q;
`else
    assign busy = 1'b1;
`endif

    for (genvar k = 0; k < NB; k++) begin : g_lane
        gen_ramp_scale #(
            .R(R)
        ) u_scale (
            .clk    (clk),
            .a      (outA),
            .factor (ramp_B_factor[k*R +: R]),
            .y      (outB[k*R +: R])
        );
    end

endmodule
